// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encodings, line levels and parity helper.
// The state encoding is shared with the uart_slave receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int   DATA_BITS  = 8;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  function automatic logic calc_parity(input logic [DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: pulses bit_end on the last clk of every serial bit.
// Down-counter reloaded on restart or at terminal count; constant 0 when CLKS_PER_BIT=1.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_end
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_end = (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || bit_end) begin
      cnt <= LAST;
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/uart_master.sv
// UART transmitter: start, 8 data bits LSB first, parity, stop; one-deep holding
// register so the next word can be queued while a frame is on the line.
//
// state  | meaning
// IDLE   | line high, waiting for a held word with en_tx
// START  | driving the start bit
// DATA   | driving shift[0], eight bits
// PARITY | driving the latched parity bit
// STOP   | driving the stop bit; may chain straight into START
module uart_master
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_tx,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 u_tx,
  output logic                 u_tx_busy,
  output logic                 u_tx_done
);

  uart_state_e          state, state_n;
  logic [DATA_BITS-1:0] hold_q, hold_n, shift_q, shift_n;
  logic                 hold_full, hold_full_n;
  logic [2:0]           bit_idx, bit_idx_n;
  logic                 parity_q, parity_n;
  logic                 u_tx_n, done_n;
  logic                 launch, accept, bit_end;

  assign tx_ready  = en_tx & ~hold_full;
  assign accept    = tx_valid & tx_ready;
  assign u_tx_busy = (state != IDLE);

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (launch),
    .bit_end (bit_end)
  );

  always_comb begin
    state_n   = state;
    shift_n   = shift_q;
    bit_idx_n = bit_idx;
    parity_n  = parity_q;
    launch    = 1'b0;
    done_n    = 1'b0;
    case (state)
      IDLE:   if (hold_full && en_tx) launch = 1'b1;
      START:  if (bit_end) state_n = DATA;
      DATA: begin
        if (bit_end) begin
          shift_n   = shift_q >> 1;
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = PARITY;
        end
      end
      PARITY: if (bit_end) state_n = STOP;
      STOP: begin
        if (bit_end) begin
          done_n = 1'b1;
          if (hold_full && en_tx) launch = 1'b1;
          else                    state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (launch) begin
      state_n   = START;
      shift_n   = hold_q;
      bit_idx_n = 3'd0;
      parity_n  = calc_parity(hold_q, PARITY_ODD);
    end

    hold_n      = accept ? din : hold_q;
    hold_full_n = launch ? 1'b0 : (accept ? 1'b1 : hold_full);

    // u_tx is registered from the next state so the line and state change together
    case (state_n)
      START:   u_tx_n = START_BIT;
      DATA:    u_tx_n = shift_n[0];
      PARITY:  u_tx_n = parity_n;
      STOP:    u_tx_n = STOP_BIT;
      default: u_tx_n = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hold_q    <= '0;
      hold_full <= 1'b0;
      shift_q   <= '0;
      bit_idx   <= 3'd0;
      parity_q  <= 1'b0;
      u_tx      <= IDLE_LEVEL;
      u_tx_done <= 1'b0;
    end else begin
      state     <= state_n;
      hold_q    <= hold_n;
      hold_full <= hold_full_n;
      shift_q   <= shift_n;
      bit_idx   <= bit_idx_n;
      parity_q  <= parity_n;
      u_tx      <= u_tx_n;
      u_tx_done <= done_n;
    end
  end

endmodule

// File: tb/tb_uart_master.sv
// Bench for uart_master: three instances (1 clk/bit even, 1 clk/bit odd, 4 clk/bit),
// a negedge-sampling receiver model with an expected-word scoreboard.
module tb_uart_master;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       en_a, valid_a, ready_a, tx_a, busy_a, done_a;
  logic [7:0] din_a;
  logic       en_o, valid_o, ready_o, tx_o, busy_o, done_o;
  logic [7:0] din_o;
  logic       en_s, valid_s, ready_s, tx_s, busy_s, done_s;
  logic [7:0] din_s;

  uart_master #(.CLKS_PER_BIT(1), .PARITY_ODD(1'b0)) dut_a (
    .clk(clk), .rst(rst), .en_tx(en_a), .din(din_a), .tx_valid(valid_a),
    .tx_ready(ready_a), .u_tx(tx_a), .u_tx_busy(busy_a), .u_tx_done(done_a));
  uart_master #(.CLKS_PER_BIT(1), .PARITY_ODD(1'b1)) dut_o (
    .clk(clk), .rst(rst), .en_tx(en_o), .din(din_o), .tx_valid(valid_o),
    .tx_ready(ready_o), .u_tx(tx_o), .u_tx_busy(busy_o), .u_tx_done(done_o));
  uart_master #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b0)) dut_s (
    .clk(clk), .rst(rst), .en_tx(en_s), .din(din_s), .tx_valid(valid_s),
    .tx_ready(ready_s), .u_tx(tx_s), .u_tx_busy(busy_s), .u_tx_done(done_s));

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic line_a[$], bsy_a[$], dn_a[$], rdy_a[$];
  logic line_o[$];
  logic line_s[$], bsy_s[$], dn_s[$];
  logic log_on = 1'b0;

  always @(negedge clk) begin
    if (log_on) begin
      line_a.push_back(tx_a); bsy_a.push_back(busy_a); dn_a.push_back(done_a);
      rdy_a.push_back(ready_a); line_o.push_back(tx_o);
      line_s.push_back(tx_s); bsy_s.push_back(busy_s); dn_s.push_back(done_s);
    end
  end

  // Receiver model for dut_a: bit0..7 data, bit8 parity, bit9 stop
  int         rx_n = 0;
  int         rx_frames = 0;
  logic [9:0] rx_sh;
  logic [7:0] rx_exp;
  always @(negedge clk) begin
    if (rst) begin
      rx_n = 0;
    end else if (rx_n == 0) begin
      if (tx_a === 1'b0) rx_n = 1;
    end else begin
      rx_sh[rx_n-1] = tx_a;
      rx_n++;
      if (rx_n == 11) begin
        rx_n = 0;
        rx_frames++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rx_unexpected: got frame %h, no word expected", rx_sh);
        end else begin
          rx_exp = exp_q.pop_front();
          if (rx_sh !== {1'b1, ^rx_exp, rx_exp}) begin
            bad++;
            $display("FAIL rx_frame: got %h required %h", rx_sh, {1'b1, ^rx_exp, rx_exp});
          end
        end
      end
    end
  end

  function automatic logic [10:0] frame_bits(input logic [7:0] w, input logic odd);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = w[i];
    f[9]  = (^w) ^ odd;
    f[10] = 1'b1;
    return f;
  endfunction

  function automatic logic [10:0] grab(input int which, input int base);
    logic [10:0] g;
    for (int i = 0; i < 11; i++) g[i] = (which == 0) ? line_a[base+i] : line_o[base+i];
    return g;
  endfunction

  task automatic clear_logs();
    line_a.delete(); bsy_a.delete(); dn_a.delete(); rdy_a.delete();
    line_o.delete(); line_s.delete(); bsy_s.delete(); dn_s.delete();
  endtask

  task automatic wait_log(input int n);
    int guard = 0;
    while (line_a.size() < n && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (line_a.size() < n) begin
      total++; bad++;
      $display("FAIL wait_log: got %0d samples required %0d", line_a.size(), n);
    end
  endtask

  task automatic send(input int which, input logic [7:0] w);
    int   n = 0;
    logic rdy;
    @(negedge clk);
    if (which == 0) begin din_a = w; valid_a = 1'b1; end
    else            begin din_o = w; valid_o = 1'b1; end
    forever begin
      rdy = (which == 0) ? ready_a : ready_o;
      if (rdy) break;
      n++;
      if (n > 200) begin
        total++; bad++;
        $display("FAIL send_timeout: got tx_ready=0 required 1");
        valid_a = 1'b0; valid_o = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    valid_a = 1'b0; valid_o = 1'b0;
    if (which == 0) exp_q.push_back(w);
  endtask

  task automatic test_reset();
    en_a = 1'b1; en_o = 1'b1; en_s = 1'b1;
    valid_a = 1'b0; valid_o = 1'b0; valid_s = 1'b0;
    din_a = 8'h00; din_o = 8'h00; din_s = 8'h00;
    #1 rst = 1'b1;
    #2;
    total++; if ({tx_a, busy_a, done_a, ready_a} !== 4'b1001) begin bad++;
      $display("FAIL reset_a: got %b required 1001", {tx_a, busy_a, done_a, ready_a}); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    total++; if ({tx_o, busy_o, done_o, ready_o} !== 4'b1001) begin bad++;
      $display("FAIL reset_o: got %b required 1001", {tx_o, busy_o, done_o, ready_o}); end
    total++; if ({tx_s, busy_s, done_s, ready_s} !== 4'b1001) begin bad++;
      $display("FAIL reset_s: got %b required 1001", {tx_s, busy_s, done_s, ready_s}); end
  endtask

  task automatic test_a5();
    int          nd = 0;
    logic [10:0] lit = 11'b10101001010;
    clear_logs();
    send(0, 8'hA5);
    log_on = 1'b1;
    wait_log(14);
    log_on = 1'b0;
    total++; if ({line_a[0], bsy_a[0], rdy_a[0]} !== 3'b100) begin bad++;
      $display("FAIL a5_latency: got tx/busy/ready=%b required 100", {line_a[0], bsy_a[0], rdy_a[0]}); end
    total++; if (grab(0, 1) !== lit) begin bad++;
      $display("FAIL a5_frame: got %b required %b", grab(0, 1), lit); end
    total++; if (rdy_a[1] !== 1'b1) begin bad++;
      $display("FAIL a5_ready_after_launch: got %b required 1", rdy_a[1]); end
    for (int i = 0; i < 14; i++) nd += int'(dn_a[i]);
    total++; if (nd != 1 || dn_a[12] !== 1'b1 || bsy_a[11] !== 1'b1 || bsy_a[12] !== 1'b0) begin bad++;
      $display("FAIL a5_done_busy: got done_count=%0d done12=%b busy11=%b busy12=%b required 1 1 1 0",
               nd, dn_a[12], bsy_a[11], bsy_a[12]); end
  endtask

  task automatic test_parity();
    clear_logs();
    send(0, 8'h07);
    log_on = 1'b1; wait_log(13); log_on = 1'b0;
    total++; if (grab(0, 1) !== frame_bits(8'h07, 1'b0)) begin bad++;
      $display("FAIL parity_even_07: got %b required %b", grab(0, 1), frame_bits(8'h07, 1'b0)); end
    total++; if (line_a[10] !== 1'b1) begin bad++;
      $display("FAIL parity_even_bit: got %b required 1", line_a[10]); end
    clear_logs();
    send(1, 8'h07);
    log_on = 1'b1; wait_log(13); log_on = 1'b0;
    total++; if (grab(1, 1) !== frame_bits(8'h07, 1'b1)) begin bad++;
      $display("FAIL parity_odd_07: got %b required %b", grab(1, 1), frame_bits(8'h07, 1'b1)); end
    total++; if (line_o[10] !== 1'b0) begin bad++;
      $display("FAIL parity_odd_bit: got %b required 0", line_o[10]); end
  endtask

  task automatic test_back_to_back();
    int nb = 0;
    int nd = 0;
    clear_logs();
    send(0, 8'h00);
    log_on = 1'b1;
    send(0, 8'hFF);
    wait_log(25);
    log_on = 1'b0;
    total++; if ({grab(0, 12), grab(0, 1)} !== {frame_bits(8'hFF, 1'b0), frame_bits(8'h00, 1'b0)}) begin bad++;
      $display("FAIL b2b_frames: got %b_%b required %b_%b", grab(0, 12), grab(0, 1),
               frame_bits(8'hFF, 1'b0), frame_bits(8'h00, 1'b0)); end
    for (int i = 0; i < 25; i++) begin nb += int'(bsy_a[i]); nd += int'(dn_a[i]); end
    total++; if (nb != 22 || bsy_a[1] !== 1'b1 || bsy_a[22] !== 1'b1) begin bad++;
      $display("FAIL b2b_busy: got busy_cycles=%0d required 22 contiguous", nb); end
    total++; if (nd != 2 || dn_a[12] !== 1'b1 || dn_a[23] !== 1'b1) begin bad++;
      $display("FAIL b2b_done: got count=%0d d12=%b d23=%b required 2 1 1", nd, dn_a[12], dn_a[23]); end
  endtask

  task automatic test_loopback();
    int f0 = rx_frames;
    int guard = 0;
    for (int w = 0; w < 256; w++) send(0, 8'(w));
    while (exp_q.size() != 0 && guard < 100) begin @(negedge clk); guard++; end
    total++; if (rx_frames - f0 != 256 || exp_q.size() != 0) begin bad++;
      $display("FAIL loopback_count: got frames=%0d pending=%0d required 256 0", rx_frames - f0, exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int nz = 0;
    send(0, 8'h5A);
    send(0, 8'h33);
    repeat (3) @(posedge clk);
    #2;
    total++; if (busy_a !== 1'b1 || ready_a !== 1'b0) begin bad++;
      $display("FAIL midrst_pre: got busy=%b ready=%b required 1 0", busy_a, ready_a); end
    rst = 1'b1;
    #1;
    total++; if ({tx_a, busy_a, done_a} !== 3'b100) begin bad++;
      $display("FAIL midrst_async: got tx/busy/done=%b required 100", {tx_a, busy_a, done_a}); end
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    exp_q.delete();
    clear_logs();
    log_on = 1'b1; wait_log(15); log_on = 1'b0;
    for (int i = 0; i < 15; i++) if (line_a[i] !== 1'b1 || bsy_a[i] !== 1'b0 || rdy_a[i] !== 1'b1) nz++;
    total++; if (nz != 0) begin bad++;
      $display("FAIL midrst_residual: got %0d non-idle cycles required 0", nz); end
  endtask

  task automatic test_slow();
    int          nz = 0;
    int          nb = 0;
    int          nd = 0;
    logic [43:0] obs, expv;
    logic [10:0] f;
    en_s = 1'b0;
    @(negedge clk);
    din_s = 8'h3C; valid_s = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (ready_s !== 1'b0 || busy_s !== 1'b0 || tx_s !== 1'b1) nz++;
    end
    total++; if (nz != 0) begin bad++;
      $display("FAIL slow_disabled: got %0d cycles with ready/busy/start required 0", nz); end
    en_s = 1'b1;
    @(posedge clk);
    #1 valid_s = 1'b0;
    din_s = 8'hFF;
    clear_logs();
    log_on = 1'b1; wait_log(48); log_on = 1'b0;
    f = frame_bits(8'h3C, 1'b0);
    for (int i = 0; i < 44; i++) begin obs[i] = line_s[1+i]; expv[i] = f[i/4]; end
    total++; if (line_s[0] !== 1'b1 || obs !== expv) begin bad++;
      $display("FAIL slow_frame: got idle=%b %h required 1 %h", line_s[0], obs, expv); end
    for (int i = 0; i < 48; i++) begin nb += int'(bsy_s[i]); nd += int'(dn_s[i]); end
    total++; if (nb != 44 || bsy_s[44] !== 1'b1 || bsy_s[45] !== 1'b0) begin bad++;
      $display("FAIL slow_busy: got busy_cycles=%0d required 44", nb); end
    total++; if (nd != 1 || dn_s[45] !== 1'b1) begin bad++;
      $display("FAIL slow_done: got count=%0d d45=%b required 1 1", nd, dn_s[45]); end
  endtask

  initial begin
    test_reset();
    test_a5();
    test_parity();
    test_back_to_back();
    test_loopback();
    test_reset_mid();
    test_slow();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
